magic_seq_axil_slave: RTL
=========================

MAGIC_SEQ_AXIL_SLAVE -- requirements
Module: magic_seq_axil_slave

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- ADDR_W, 8, AXI-Lite address width.
- BANK1_* widths, identical defaults to the sequencer core (INDEX 2, ADDR 32, SIZE 26, STATUS 2, PROFILE 4).
- BANK0_CONTROL_W, 4, control field width.
- BANK0_STATUS_W, 4, status field width.
- RD_TIMEOUT, 16, cycles to wait for read-ready.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
REQ-003 The AXI-Lite slave ports SHALL be:
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write-address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write-data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write-response channel.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read-address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read-data channel.
REQ-004 Core-side outputs SHALL be:
- ext_bank1_inp_{index,src_addr,src_size,des_addr,des_size,status,profile}  out  field widths  staged values.
- ext_bank1_set_{src_addr,src_size,status,profile}  out  1  set strobes.
- ext_bank1_out_index  out  INDEX  read slot.
- ext_bank1_out_req  out  1  read request.
- ext_bank0_inp_control/set_control  out  4/1  control value and strobe.
- ext_bank0_inp_endCnt/set_endCnt  out  INDEX/1  endCnt value and strobe.
REQ-005 Core-side inputs SHALL be:
- bank1_set_actual_{src_addr,src_size,status,profile}  in  1  acceptance flags.
- ext_bank1_out_{src_addr,src_size,des_addr,des_size,status,profile,ready}  in  field widths  read data.
- ext_bank0_out_{status,mainCnt,endCnt}  in  4/INDEX/INDEX  bank0 state.

Function
REQ-006 The register map (word offsets) SHALL be:
- 0x00 CONTROL, write-only.
- 0x04 STATUS, read-only.
- 0x08 MAINCNT, read-only.
- 0x0C ENDCNT, read/write.
- 0x40 WR_INDEX, read/write.
- 0x44/0x48/0x4C/0x50/0x54/0x58: SRC_ADDR/SRC_SIZE/DES_ADDR/DES_SIZE/STATUS/PROFILE, write-staged; reads go through the core.
- 0x60 RD_INDEX, read/write.
REQ-007 The write FSM SHALL have states W_IDLE -> W_EXEC -> W_RESP -> W_IDLE.
- W_IDLE accepts AW and W independently, in either order or together; each ready is high until its beat is captured.
- Leave W_IDLE only when both beats are held.
REQ-008 W_EXEC SHALL last exactly one cycle.
- Drive the staged value and pulse the matching set strobe for that cycle only.
- Sample the acceptance flag in the same cycle.
REQ-009 Write responses SHALL be:
- OKAY when the bank1 acceptance flag is high.
- SLVERR when a bank1 acceptance flag is low; the staging register still updates.
- CONTROL and ENDCNT writes always pulse their strobe; ENDCNT returns SLVERR when ext_bank0_out_status != 0.
- DES_ADDR/DES_SIZE writes stage only, no strobe, OKAY.
REQ-010 Writes with wstrb != 4'hF SHALL return SLVERR with no side effect.
- Unmapped addresses SHALL return DECERR (2'b11) with no side effect.
- Data wider than a field is truncated; narrower fields are zero-extended on read.
REQ-011 W_RESP SHALL hold bvalid and bresp stable until bready; the return to W_IDLE happens in the handshake cycle.
REQ-012 The read FSM SHALL have states R_IDLE -> R_REQ -> R_RESP -> R_IDLE; arready is high only in R_IDLE.
REQ-013 Bank0 and index reads SHALL skip R_REQ, capture data on the AR handshake, and present rvalid the next cycle.
REQ-014 Bank1 field reads SHALL use R_REQ:
- Assert ext_bank1_out_req with ext_bank1_out_index = RD_INDEX.
- Count cycles from 0.
- On ext_bank1_out_ready, capture the field and return OKAY.
- At count RD_TIMEOUT-1 without ready, return rdata=0 with SLVERR.
- ext_bank1_out_req deasserts on entry to R_RESP.
REQ-015 Read and write FSMs SHALL be independent and may be active in the same cycle.
REQ-016 At most one bank1 set strobe SHALL be high in any cycle.

Reset
REQ-017 On reset the block SHALL:
- Return both FSMs to idle.
- Drive all valid and strobe outputs, out_req and bresp/rresp to 0; awready/wready/arready go to 1 in the first post-reset cycle.
- Zero all staging and index registers.
REQ-018 Reset mid-transaction SHALL abort the transaction with no response issued and no strobe emitted.

Structure
REQ-019 A shared package magic_seq_pkg SHALL hold the register offsets, AXI response codes, and the core STATUS_/CTRL_ encodings.
REQ-020 The block SHALL be single-level, with no sub-modules; the read-timeout counter is inline.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- AW at t, W at t+3, addr 0x44, data 0x1000_0000, core in SHUTDOWN -> set_src_addr high exactly one cycle, inp_src_addr=0x1000_0000, bresp OKAY.
- Same write with ext_bank0_out_status=4'b0001 (acceptance low) -> one strobe pulse, bresp SLVERR.
- RD_INDEX=2, read 0x58, ext_bank1_out_ready high two cycles after out_req -> out_index=2, rdata=profile zero-extended, OKAY.
- Read 0x44 with ready held low -> out_req high for 16 cycles, rdata=0, SLVERR.
- Write 0x7C -> DECERR, no strobe; write 0x00 with wstrb=4'h3 -> SLVERR, no set_control.
- Reset asserted while in R_REQ -> out_req 0 next cycle, no rvalid, arready 1 after reset.

Source files
------------

// File: rtl/magic_seq_pkg.sv
// Shared definitions for the magic sequencer: register offsets, AXI response
// codes, core status/control encodings and the slave FSM state types.
package magic_seq_pkg;

    localparam int unsigned OFF_CONTROL   = 'h00;
    localparam int unsigned OFF_STATUS    = 'h04;
    localparam int unsigned OFF_MAINCNT   = 'h08;
    localparam int unsigned OFF_ENDCNT    = 'h0C;
    localparam int unsigned OFF_WR_INDEX  = 'h40;
    localparam int unsigned OFF_SRC_ADDR  = 'h44;
    localparam int unsigned OFF_SRC_SIZE  = 'h48;
    localparam int unsigned OFF_DES_ADDR  = 'h4C;
    localparam int unsigned OFF_DES_SIZE  = 'h50;
    localparam int unsigned OFF_B1_STATUS = 'h54;
    localparam int unsigned OFF_PROFILE   = 'h58;
    localparam int unsigned OFF_RD_INDEX  = 'h60;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] STATUS_SHUTDOWN = 4'b0000;
    localparam logic [3:0] STATUS_RUNNING  = 4'b0001;
    localparam logic [3:0] STATUS_PAUSED   = 4'b0010;
    localparam logic [3:0] STATUS_ERROR    = 4'b0011;

    localparam logic [3:0] CTRL_NOP   = 4'b0000;
    localparam logic [3:0] CTRL_START = 4'b0001;
    localparam logic [3:0] CTRL_STOP  = 4'b0010;
    localparam logic [3:0] CTRL_RESET = 4'b0011;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rd_state_e;
    typedef enum logic [2:0] {
        F_SRC_ADDR, F_SRC_SIZE, F_DES_ADDR, F_DES_SIZE, F_STATUS, F_PROFILE
    } b1_field_e;

endpackage

// File: rtl/magic_seq_axil_slave.sv
// AXI-Lite register slave for the magic sequencer: stages bank1/bank0 writes
// into the core with one-cycle set strobes and fetches bank1 fields on read.
module magic_seq_axil_slave
    import magic_seq_pkg::*;
#(
    parameter int ADDR_W           = 8,
    parameter int BANK1_INDEX_W    = 2,
    parameter int BANK1_ADDR_W     = 32,
    parameter int BANK1_SIZE_W     = 26,
    parameter int BANK1_STATUS_W   = 2,
    parameter int BANK1_PROFILE_W  = 4,
    parameter int BANK0_CONTROL_W  = 4,
    parameter int BANK0_STATUS_W   = 4,
    parameter int RD_TIMEOUT       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [31:0]                 s_axi_wdata,
    input  logic [3:0]                  s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ADDR_W-1:0]           s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [31:0]                 s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [BANK1_INDEX_W-1:0]    ext_bank1_inp_index,
    output logic [BANK1_ADDR_W-1:0]     ext_bank1_inp_src_addr,
    output logic [BANK1_SIZE_W-1:0]     ext_bank1_inp_src_size,
    output logic [BANK1_ADDR_W-1:0]     ext_bank1_inp_des_addr,
    output logic [BANK1_SIZE_W-1:0]     ext_bank1_inp_des_size,
    output logic [BANK1_STATUS_W-1:0]   ext_bank1_inp_status,
    output logic [BANK1_PROFILE_W-1:0]  ext_bank1_inp_profile,
    output logic                        ext_bank1_set_src_addr,
    output logic                        ext_bank1_set_src_size,
    output logic                        ext_bank1_set_status,
    output logic                        ext_bank1_set_profile,
    output logic [BANK1_INDEX_W-1:0]    ext_bank1_out_index,
    output logic                        ext_bank1_out_req,
    output logic [BANK0_CONTROL_W-1:0]  ext_bank0_inp_control,
    output logic                        ext_bank0_set_control,
    output logic [BANK1_INDEX_W-1:0]    ext_bank0_inp_endCnt,
    output logic                        ext_bank0_set_endCnt,
    input  logic                        bank1_set_actual_src_addr,
    input  logic                        bank1_set_actual_src_size,
    input  logic                        bank1_set_actual_status,
    input  logic                        bank1_set_actual_profile,
    input  logic [BANK1_ADDR_W-1:0]     ext_bank1_out_src_addr,
    input  logic [BANK1_SIZE_W-1:0]     ext_bank1_out_src_size,
    input  logic [BANK1_ADDR_W-1:0]     ext_bank1_out_des_addr,
    input  logic [BANK1_SIZE_W-1:0]     ext_bank1_out_des_size,
    input  logic [BANK1_STATUS_W-1:0]   ext_bank1_out_status,
    input  logic [BANK1_PROFILE_W-1:0]  ext_bank1_out_profile,
    input  logic                        ext_bank1_out_ready,
    input  logic [BANK0_STATUS_W-1:0]   ext_bank0_out_status,
    input  logic [BANK1_INDEX_W-1:0]    ext_bank0_out_mainCnt,
    input  logic [BANK1_INDEX_W-1:0]    ext_bank0_out_endCnt
);

    localparam int CNT_W = $clog2(RD_TIMEOUT) + 1;

    wr_state_e                    wr_state_q, wr_state_d;
    logic                         aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0]            awaddr_q, awaddr_d;
    logic [31:0]                  wdata_q, wdata_d;
    logic [3:0]                   wstrb_q, wstrb_d;
    logic [1:0]                   bresp_q, bresp_d;
    logic [BANK1_INDEX_W-1:0]     wr_index_q, wr_index_d, rd_index_q, rd_index_d;
    logic [BANK1_ADDR_W-1:0]      src_addr_q, src_addr_d, des_addr_q, des_addr_d;
    logic [BANK1_SIZE_W-1:0]      src_size_q, src_size_d, des_size_q, des_size_d;
    logic [BANK1_STATUS_W-1:0]    status_q, status_d;
    logic [BANK1_PROFILE_W-1:0]   profile_q, profile_d;
    logic [BANK0_CONTROL_W-1:0]   control_q, control_d;
    logic [BANK1_INDEX_W-1:0]     endcnt_q, endcnt_d;

    rd_state_e                    rd_state_q, rd_state_d;
    b1_field_e                    rfield_q, rfield_d;
    logic [CNT_W-1:0]             rd_cnt_q, rd_cnt_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic [1:0]                   rresp_q, rresp_d;

    logic wr_mapped;
    logic strobe_en;

    assign wr_mapped = awaddr_q inside {
        ADDR_W'(OFF_CONTROL), ADDR_W'(OFF_STATUS), ADDR_W'(OFF_MAINCNT),
        ADDR_W'(OFF_ENDCNT), ADDR_W'(OFF_WR_INDEX), ADDR_W'(OFF_SRC_ADDR),
        ADDR_W'(OFF_SRC_SIZE), ADDR_W'(OFF_DES_ADDR), ADDR_W'(OFF_DES_SIZE),
        ADDR_W'(OFF_B1_STATUS), ADDR_W'(OFF_PROFILE), ADDR_W'(OFF_RD_INDEX)};

    // A reset landing on the execute cycle must not leak a strobe to the core.
    assign strobe_en = !reset;

    always_comb begin
        wr_state_d  = wr_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        wr_index_d  = wr_index_q;
        rd_index_d  = rd_index_q;
        src_addr_d  = src_addr_q;
        src_size_d  = src_size_q;
        des_addr_d  = des_addr_q;
        des_size_d  = des_size_q;
        status_d    = status_q;
        profile_d   = profile_q;
        control_d   = control_q;
        endcnt_d    = endcnt_q;
        s_axi_awready          = 1'b0;
        s_axi_wready           = 1'b0;
        s_axi_bvalid           = 1'b0;
        ext_bank1_set_src_addr = 1'b0;
        ext_bank1_set_src_size = 1'b0;
        ext_bank1_set_status   = 1'b0;
        ext_bank1_set_profile  = 1'b0;
        ext_bank0_set_control  = 1'b0;
        ext_bank0_set_endCnt   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                s_axi_awready = !aw_held_q;
                s_axi_wready  = !w_held_q;
                if (s_axi_awvalid && !aw_held_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi_awaddr;
                end
                if (s_axi_wvalid && !w_held_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                if (aw_held_d && w_held_d) wr_state_d = W_EXEC;
            end
            W_EXEC: begin
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
                wr_state_d = W_RESP;
                bresp_d    = RESP_OKAY;
                if (!wr_mapped) begin
                    bresp_d = RESP_DECERR;
                end else if (wstrb_q != 4'hF) begin
                    bresp_d = RESP_SLVERR;
                end else begin
                    case (awaddr_q)
                        ADDR_W'(OFF_CONTROL): begin
                            control_d             = wdata_q[BANK0_CONTROL_W-1:0];
                            ext_bank0_set_control = strobe_en;
                        end
                        ADDR_W'(OFF_ENDCNT): begin
                            endcnt_d             = wdata_q[BANK1_INDEX_W-1:0];
                            ext_bank0_set_endCnt = strobe_en;
                            if (ext_bank0_out_status != '0) bresp_d = RESP_SLVERR;
                        end
                        ADDR_W'(OFF_WR_INDEX): wr_index_d = wdata_q[BANK1_INDEX_W-1:0];
                        ADDR_W'(OFF_RD_INDEX): rd_index_d = wdata_q[BANK1_INDEX_W-1:0];
                        ADDR_W'(OFF_SRC_ADDR): begin
                            src_addr_d             = wdata_q[BANK1_ADDR_W-1:0];
                            ext_bank1_set_src_addr = strobe_en;
                            if (!bank1_set_actual_src_addr) bresp_d = RESP_SLVERR;
                        end
                        ADDR_W'(OFF_SRC_SIZE): begin
                            src_size_d             = wdata_q[BANK1_SIZE_W-1:0];
                            ext_bank1_set_src_size = strobe_en;
                            if (!bank1_set_actual_src_size) bresp_d = RESP_SLVERR;
                        end
                        ADDR_W'(OFF_DES_ADDR): des_addr_d = wdata_q[BANK1_ADDR_W-1:0];
                        ADDR_W'(OFF_DES_SIZE): des_size_d = wdata_q[BANK1_SIZE_W-1:0];
                        ADDR_W'(OFF_B1_STATUS): begin
                            status_d             = wdata_q[BANK1_STATUS_W-1:0];
                            ext_bank1_set_status = strobe_en;
                            if (!bank1_set_actual_status) bresp_d = RESP_SLVERR;
                        end
                        ADDR_W'(OFF_PROFILE): begin
                            profile_d             = wdata_q[BANK1_PROFILE_W-1:0];
                            ext_bank1_set_profile = strobe_en;
                            if (!bank1_set_actual_profile) bresp_d = RESP_SLVERR;
                        end
                        default: bresp_d = RESP_SLVERR; // read-only registers
                    endcase
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d        = rd_state_q;
        rfield_d          = rfield_q;
        rd_cnt_d          = rd_cnt_q;
        rdata_d           = rdata_q;
        rresp_d           = rresp_q;
        s_axi_arready     = 1'b0;
        s_axi_rvalid      = 1'b0;
        ext_bank1_out_req = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) begin
                    rd_state_d = R_RESP;
                    rdata_d    = '0;
                    rresp_d    = RESP_OKAY;
                    rd_cnt_d   = '0;
                    case (s_axi_araddr)
                        ADDR_W'(OFF_STATUS):   rdata_d = 32'(ext_bank0_out_status);
                        ADDR_W'(OFF_MAINCNT):  rdata_d = 32'(ext_bank0_out_mainCnt);
                        ADDR_W'(OFF_ENDCNT):   rdata_d = 32'(ext_bank0_out_endCnt);
                        ADDR_W'(OFF_WR_INDEX): rdata_d = 32'(wr_index_q);
                        ADDR_W'(OFF_RD_INDEX): rdata_d = 32'(rd_index_q);
                        ADDR_W'(OFF_CONTROL):  rresp_d = RESP_SLVERR;
                        ADDR_W'(OFF_SRC_ADDR):  begin rfield_d = F_SRC_ADDR; rd_state_d = R_REQ; end
                        ADDR_W'(OFF_SRC_SIZE):  begin rfield_d = F_SRC_SIZE; rd_state_d = R_REQ; end
                        ADDR_W'(OFF_DES_ADDR):  begin rfield_d = F_DES_ADDR; rd_state_d = R_REQ; end
                        ADDR_W'(OFF_DES_SIZE):  begin rfield_d = F_DES_SIZE; rd_state_d = R_REQ; end
                        ADDR_W'(OFF_B1_STATUS): begin rfield_d = F_STATUS;   rd_state_d = R_REQ; end
                        ADDR_W'(OFF_PROFILE):   begin rfield_d = F_PROFILE;  rd_state_d = R_REQ; end
                        default: rresp_d = RESP_DECERR;
                    endcase
                end
            end
            R_REQ: begin
                ext_bank1_out_req = 1'b1;
                if (ext_bank1_out_ready) begin
                    rd_state_d = R_RESP;
                    rresp_d    = RESP_OKAY;
                    case (rfield_q)
                        F_SRC_ADDR: rdata_d = 32'(ext_bank1_out_src_addr);
                        F_SRC_SIZE: rdata_d = 32'(ext_bank1_out_src_size);
                        F_DES_ADDR: rdata_d = 32'(ext_bank1_out_des_addr);
                        F_DES_SIZE: rdata_d = 32'(ext_bank1_out_des_size);
                        F_STATUS:   rdata_d = 32'(ext_bank1_out_status);
                        default:    rdata_d = 32'(ext_bank1_out_profile);
                    endcase
                end else if (rd_cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    rd_state_d = R_RESP;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            R_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_index_q <= '0;
            rd_index_q <= '0;
            src_addr_q <= '0;
            src_size_q <= '0;
            des_addr_q <= '0;
            des_size_q <= '0;
            status_q   <= '0;
            profile_q  <= '0;
            control_q  <= '0;
            endcnt_q   <= '0;
            rd_state_q <= R_IDLE;
            rfield_q   <= F_SRC_ADDR;
            rd_cnt_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_index_q <= wr_index_d;
            rd_index_q <= rd_index_d;
            src_addr_q <= src_addr_d;
            src_size_q <= src_size_d;
            des_addr_q <= des_addr_d;
            des_size_q <= des_size_d;
            status_q   <= status_d;
            profile_q  <= profile_d;
            control_q  <= control_d;
            endcnt_q   <= endcnt_d;
            rd_state_q <= rd_state_d;
            rfield_q   <= rfield_d;
            rd_cnt_q   <= rd_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // The core sees the staged value during the strobe cycle itself.
    assign ext_bank1_inp_index    = wr_index_d;
    assign ext_bank1_inp_src_addr = src_addr_d;
    assign ext_bank1_inp_src_size = src_size_d;
    assign ext_bank1_inp_des_addr = des_addr_d;
    assign ext_bank1_inp_des_size = des_size_d;
    assign ext_bank1_inp_status   = status_d;
    assign ext_bank1_inp_profile  = profile_d;
    assign ext_bank0_inp_control  = control_d;
    assign ext_bank0_inp_endCnt   = endcnt_d;
    assign ext_bank1_out_index    = rd_index_q;
    assign s_axi_bresp            = bresp_q;
    assign s_axi_rdata            = rdata_q;
    assign s_axi_rresp            = rresp_q;

endmodule
